// File: rtl/plms_pkg.sv
// Shared widths, complex sample/weight types and rounding constant for the PLMS output combiner.
package plms_pkg;

    localparam int unsigned DW   = 18;
    localparam int unsigned WW   = 18;
    localparam int unsigned FRAC = 16;
    localparam int unsigned OW   = 18;

    typedef struct packed {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
    } cplx_t;

    typedef struct packed {
        logic signed [WW-1:0] i;
        logic signed [WW-1:0] q;
    } cwgt_t;

    // Half an output LSB in the fixed-point product domain.
    function automatic longint round_const(input int unsigned frac);
        return longint'(1) << (frac - 1);
    endfunction

    localparam longint ROUND_CONST = round_const(FRAC);

endpackage

// File: rtl/output_plms_combiner_if.sv
// Sample stream, weight-load and status signals of the PLMS output combiner.
interface output_plms_combiner_if
    import plms_pkg::*;
#(
    parameter int unsigned DW = plms_pkg::DW,
    parameter int unsigned WW = plms_pkg::WW,
    parameter int unsigned OW = plms_pkg::OW
);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] i1;
    logic signed [DW-1:0] q1;
    logic signed [DW-1:0] i2;
    logic signed [DW-1:0] q2;

    logic                 w_wr;
    logic                 w_sel;
    logic signed [WW-1:0] w_i;
    logic signed [WW-1:0] w_q;
    logic                 w_commit;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_i;
    logic signed [OW-1:0] out_q;
    logic                 sat_flag;

    modport master (
        output in_valid, i1, q1, i2, q2,
        output w_wr, w_sel, w_i, w_q, w_commit,
        output out_ready,
        input  in_ready, out_valid, out_i, out_q, sat_flag
    );

    modport slave (
        input  in_valid, i1, q1, i2, q2,
        input  w_wr, w_sel, w_i, w_q, w_commit,
        input  out_ready,
        output in_ready, out_valid, out_i, out_q, sat_flag
    );

endinterface

// File: rtl/plms_cmul_conj.sv
// conj(w) * x complex multiplier; the four partial products are registered when en is high.
module plms_cmul_conj
    import plms_pkg::*;
#(
    parameter int unsigned DW = plms_pkg::DW,
    parameter int unsigned WW = plms_pkg::WW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [DW-1:0]    x_i,
    input  logic signed [DW-1:0]    x_q,
    input  logic signed [WW-1:0]    w_i,
    input  logic signed [WW-1:0]    w_q,
    output logic signed [DW+WW-1:0] p_ii,
    output logic signed [DW+WW-1:0] p_qq,
    output logic signed [DW+WW-1:0] p_iq,
    output logic signed [DW+WW-1:0] p_qi
);

    localparam int unsigned PW = DW + WW;

    logic signed [PW-1:0] xe_i, xe_q, we_i, we_q;

    // Sign-extend first so every product is formed at full DW+WW precision.
    assign xe_i = PW'(x_i);
    assign xe_q = PW'(x_q);
    assign we_i = PW'(w_i);
    assign we_q = PW'(w_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ii <= '0;
            p_qq <= '0;
            p_iq <= '0;
            p_qi <= '0;
        end else if (en) begin
            p_ii <= we_i * xe_i;
            p_qq <= we_q * xe_q;
            p_iq <= we_i * xe_q;
            p_qi <= we_q * xe_i;
        end
    end

endmodule

// File: rtl/output_plms_combiner.sv
// Two-channel PLMS beamformer output: y = conj(w1)*x1 + conj(w2)*x2, 3-stage pipeline.
// Define OUTPUT_SAT_EN for saturating output with sticky sat_flag; otherwise outputs wrap.
module output_plms_combiner
    import plms_pkg::*;
#(
    parameter int unsigned DW   = plms_pkg::DW,
    parameter int unsigned WW   = plms_pkg::WW,
    parameter int unsigned FRAC = plms_pkg::FRAC,
    parameter int unsigned OW   = plms_pkg::OW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output_plms_combiner_if.slave  bus
);

    localparam int unsigned PW = DW + WW;
    localparam int unsigned SW = PW + 2;
    localparam int unsigned RW = SW - FRAC;

    localparam logic signed [SW-1:0] RND  = SW'(round_const(FRAC));
    localparam logic signed [RW-1:0] OMAX = RW'((longint'(1) << (OW - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    if (FRAC == 0 || FRAC >= SW || OW > RW) begin : g_param_check
        $error("output_plms_combiner: unsupported FRAC/OW combination");
    end

    logic adv;
    logic v1, v2, v3;

    // Flow control: the whole pipe moves only when the output slot is free or draining.
    assign adv          = !v3 || bus.out_ready;
    assign bus.in_ready = adv;

    // Double-buffered weight bank
    logic signed [WW-1:0] sh1_i, sh1_q, sh2_i, sh2_q;
    logic signed [WW-1:0] ac1_i, ac1_q, ac2_i, ac2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1_i <= '0;
            sh1_q <= '0;
            sh2_i <= '0;
            sh2_q <= '0;
            ac1_i <= '0;
            ac1_q <= '0;
            ac2_i <= '0;
            ac2_q <= '0;
        end else begin
            // Commit reads the shadow value from before any same-edge write.
            if (bus.w_commit) begin
                ac1_i <= sh1_i;
                ac1_q <= sh1_q;
                ac2_i <= sh2_i;
                ac2_q <= sh2_q;
            end
            if (bus.w_wr) begin
                if (!bus.w_sel) begin
                    sh1_i <= bus.w_i;
                    sh1_q <= bus.w_q;
                end else begin
                    sh2_i <= bus.w_i;
                    sh2_q <= bus.w_q;
                end
            end
        end
    end

    // Stage 1: products
    logic s1_en;
    logic signed [PW-1:0] p1_ii, p1_qq, p1_iq, p1_qi;
    logic signed [PW-1:0] p2_ii, p2_qq, p2_iq, p2_qi;

    assign s1_en = adv && bus.in_valid;

    plms_cmul_conj #(
        .DW (DW),
        .WW (WW)
    ) u_cmul1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s1_en),
        .x_i   (bus.i1),
        .x_q   (bus.q1),
        .w_i   (ac1_i),
        .w_q   (ac1_q),
        .p_ii  (p1_ii),
        .p_qq  (p1_qq),
        .p_iq  (p1_iq),
        .p_qi  (p1_qi)
    );

    plms_cmul_conj #(
        .DW (DW),
        .WW (WW)
    ) u_cmul2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s1_en),
        .x_i   (bus.i2),
        .x_q   (bus.q2),
        .w_i   (ac2_i),
        .w_q   (ac2_q),
        .p_ii  (p2_ii),
        .p_qq  (p2_qq),
        .p_iq  (p2_iq),
        .p_qi  (p2_qi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= bus.in_valid;
        end
    end

    // Stage 2: per-rail sums; two guard bits make overflow impossible.
    logic signed [SW-1:0] sum_i, sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sum_i <= '0;
            sum_q <= '0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                sum_i <= SW'(p1_ii) + SW'(p1_qq) + SW'(p2_ii) + SW'(p2_qq);
                sum_q <= SW'(p1_iq) - SW'(p1_qi) + SW'(p2_iq) - SW'(p2_qi);
            end
        end
    end

    // Stage 3: round half toward +inf, then reduce to OW bits.
    logic signed [SW-1:0] rnd_i, rnd_q;
    logic signed [RW-1:0] shr_i, shr_q;
    logic        [OW-1:0] res_i, res_q;
    logic                 unused_bits;

    assign rnd_i = sum_i + RND;
    assign rnd_q = sum_q + RND;
    assign shr_i = rnd_i[SW-1:FRAC];
    assign shr_q = rnd_q[SW-1:FRAC];

`ifdef OUTPUT_SAT_EN
    logic ovf_i, ovf_q;

    always_comb begin
        res_i = shr_i[OW-1:0];
        res_q = shr_q[OW-1:0];
        ovf_i = 1'b0;
        ovf_q = 1'b0;
        if (shr_i > OMAX) begin
            res_i = OMAX[OW-1:0];
            ovf_i = 1'b1;
        end else if (shr_i < OMIN) begin
            res_i = OMIN[OW-1:0];
            ovf_i = 1'b1;
        end
        if (shr_q > OMAX) begin
            res_q = OMAX[OW-1:0];
            ovf_q = 1'b1;
        end else if (shr_q < OMIN) begin
            res_q = OMIN[OW-1:0];
            ovf_q = 1'b1;
        end
    end

    assign unused_bits = ^{rnd_i[FRAC-1:0], rnd_q[FRAC-1:0]};

    logic sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else begin
            sat <= (sat && !bus.w_commit) || (adv && v2 && (ovf_i || ovf_q));
        end
    end

    assign bus.sat_flag = sat;
`else
    always_comb begin
        res_i = shr_i[OW-1:0];
        res_q = shr_q[OW-1:0];
    end

    assign unused_bits = ^{rnd_i[FRAC-1:0], rnd_q[FRAC-1:0], shr_i[RW-1:OW], shr_q[RW-1:OW]};
    assign bus.sat_flag = 1'b0;
`endif

    logic signed [OW-1:0] y_i, y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3  <= 1'b0;
            y_i <= '0;
            y_q <= '0;
        end else if (adv) begin
            v3 <= v2;
            if (v2) begin
                y_i <= res_i;
                y_q <= res_q;
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_i     = y_i;
    assign bus.out_q     = y_q;

endmodule

// File: tb/tb_output_plms_combiner.sv
// Self-checking bench for output_plms_combiner: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model (queue of expected results).
module tb_output_plms_combiner;
    import plms_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    output_plms_combiner_if #(.DW(DW), .WW(WW), .OW(OW)) bus ();

    output_plms_combiner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef OUTPUT_SAT_EN
    localparam longint SAT_EXP_I    = 131071;
    localparam longint SAT_EXP_FLAG = 1;
`else
    localparam longint SAT_EXP_I    = -2;
    localparam longint SAT_EXP_FLAG = 0;
`endif

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        longint yi;
        longint yq;
        bit     sat;
    } exp_t;

    exp_t   expq[$];
    longint sh_i[2], sh_q[2], ac_i[2], ac_q[2];
    bit     sat_m, pend_commit, presented;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fit(input longint v, inout bit s);
        longint mx, mn, m, w;
        mx = (longint'(1) << (OW - 1)) - 1;
        mn = -mx - 1;
        m  = longint'(1) << OW;
`ifdef OUTPUT_SAT_EN
        if (v > mx) begin
            s = 1'b1;
            return mx;
        end
        if (v < mn) begin
            s = 1'b1;
            return mn;
        end
        w = v;
`else
        w = v & (m - 1);
        if (w > mx) w = w - m;
`endif
        return w;
    endfunction

    function automatic exp_t calc(input longint x1i, input longint x1q,
                                  input longint x2i, input longint x2q);
        exp_t   e;
        longint yi, yq;
        bit     s;
        s  = 1'b0;
        yi = ac_i[0] * x1i + ac_q[0] * x1q + ac_i[1] * x2i + ac_q[1] * x2q;
        yq = ac_i[0] * x1q - ac_q[0] * x1i + ac_i[1] * x2q - ac_q[1] * x2i;
        e.yi  = fit((yi + ROUND_CONST) >>> FRAC, s);
        e.yq  = fit((yq + ROUND_CONST) >>> FRAC, s);
        e.sat = s;
        return e;
    endfunction

    // Compare process: at each negedge, settle the effects of the edge just passed, check the
    // outputs, then book what the coming edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            for (int k = 0; k < 2; k++) begin
                sh_i[k] = 0;
                sh_q[k] = 0;
                ac_i[k] = 0;
                ac_q[k] = 0;
            end
            sat_m       = 1'b0;
            pend_commit = 1'b0;
            presented   = 1'b0;
        end else begin
            if (pend_commit) sat_m = 1'b0;
            if (bus.out_valid && !presented) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    presented = 1'b1;
                    sat_m     = sat_m | expq[0].sat;
                end
            end
            chk("sat_flag", longint'(bus.sat_flag), longint'(sat_m));
            chk("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && expq.size() > 0) begin
                chk("out_i", longint'(bus.out_i), expq[0].yi);
                chk("out_q", longint'(bus.out_q), expq[0].yq);
            end
            pend_commit = bus.w_commit;
            if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                presented = 1'b0;
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(calc(longint'(bus.i1), longint'(bus.q1),
                                    longint'(bus.i2), longint'(bus.q2)));
            if (bus.w_commit) begin
                ac_i = sh_i;
                ac_q = sh_q;
            end
            if (bus.w_wr) begin
                sh_i[bus.w_sel] = longint'(bus.w_i);
                sh_q[bus.w_sel] = longint'(bus.w_q);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic write_w(input bit sel, input int wi, input int wq);
        bus.w_wr  = 1'b1;
        bus.w_sel = sel;
        bus.w_i   = WW'(wi);
        bus.w_q   = WW'(wq);
        tick();
        bus.w_wr  = 1'b0;
    endtask

    task automatic commit();
        bus.w_commit = 1'b1;
        tick();
        bus.w_commit = 1'b0;
    endtask

    task automatic load(input int w1i, input int w1q, input int w2i, input int w2q);
        write_w(1'b0, w1i, w1q);
        write_w(1'b1, w2i, w2q);
        commit();
    endtask

    task automatic set_x(input int x1i, input int x1q, input int x2i, input int x2q);
        bus.i1 = DW'(x1i);
        bus.q1 = DW'(x1q);
        bus.i2 = DW'(x2i);
        bus.q2 = DW'(x2q);
    endtask

    // One sample into an empty pipe; checks latency and literal result.
    task automatic send_one(input string name, input int x1i, input int x1q, input int x2i,
                            input int x2q, input longint ei, input longint eq);
        int n;
        idle(4);
        set_x(x1i, x1q, x2i, x2q);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 3);
        chk({name, "_i"}, longint'(bus.out_i), ei);
        chk({name, "_q"}, longint'(bus.out_q), eq);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got[$];
        longint held_i, held_q;
        int     sent, cyc;
        bit     acc;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.w_wr      = 1'b0;
        bus.w_sel     = 1'b0;
        bus.w_i       = '0;
        bus.w_q       = '0;
        bus.w_commit  = 1'b0;
        set_x(0, 0, 0, 0);

        #1;
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_out_i", longint'(bus.out_i), 0);
        chk("reset_sat", longint'(bus.sat_flag), 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        load(65536, 0, 0, 0);
        send_one("unity", 1000, -2000, 500, 7, 1000, -2000);
        chk("unity_sat", longint'(bus.sat_flag), 0);

        load(0, 65536, 0, 0);
        send_one("conj", 1000, -2000, 0, 0, -2000, -1000);

        load(32768, 0, 0, 0);
        send_one("round_pos", 3, 0, 0, 0, 2, 0);
        send_one("round_neg", -3, 0, 0, 0, -1, 0);

        load(65536, 0, 65536, 0);
        send_one("sat", 131071, 0, 131071, 0, SAT_EXP_I, 0);
        idle(1);
        chk("sat_flag_lit", longint'(bus.sat_flag), SAT_EXP_FLAG);
        commit();
        chk("sat_cleared_by_commit", longint'(bus.sat_flag), 0);

        // Backpressure: continuous input, output stalled for 5 cycles.
        load(65536, 0, 0, 65536);
        idle(4);
        sent = 0;
        cyc  = 0;
        bus.in_valid = 1'b1;
        set_x(100, -50, 3, 11);
        while (sent < 10 && cyc < 100) begin
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            #1;
            if (cyc == 4) begin
                held_i = longint'(bus.out_i);
                held_q = longint'(bus.out_q);
                chk("stall_valid", longint'(bus.out_valid), 1);
            end
            if (cyc >= 4 && cyc < 9) begin
                chk("stall_in_ready", longint'(bus.in_ready), 0);
                chk("stall_hold_i", longint'(bus.out_i), held_i);
                chk("stall_hold_q", longint'(bus.out_q), held_q);
            end
            acc = bus.in_ready;
            tick();
            if (acc) begin
                sent++;
                set_x(100 * (sent + 1), -50 * (sent + 1), 3 + sent, 11 - sent);
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(8);
        chk("bp_all_drained", expq.size(), 0);

        // Commit switchover in the middle of a stream.
        load(65536, 0, 0, 0);
        write_w(1'b0, 32768, 0);
        idle(4);
        got.delete();
        set_x(1000, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.w_commit = (k == 4);
            tick();
            bus.w_commit = 1'b0;
            if (bus.out_valid) got.push_back(longint'(bus.out_i));
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid) got.push_back(longint'(bus.out_i));
        end
        chk("switch_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("switch_s%0d", k), got[k], (k <= 4) ? 1000 : 500);

        // Asynchronous reset with three samples in flight.
        bus.in_valid = 1'b1;
        idle(3);
        bus.in_valid = 1'b0;
        chk("pre_reset_valid", longint'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", longint'(bus.out_valid), 0);
        chk("async_reset_out_i", longint'(bus.out_i), 0);
        idle(2);
        rst_n = 1'b1;
        send_one("post_reset", 1000, -2000, 500, 7, 0, 0);

        // Randomized traffic checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.i1        = DW'($urandom);
            bus.q1        = DW'($urandom);
            bus.i2        = DW'($urandom);
            bus.q2        = DW'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.w_wr      = ($urandom_range(0, 9) == 0);
            bus.w_sel     = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                bus.w_i = WW'($urandom);
                bus.w_q = WW'($urandom);
            end else begin
                bus.w_i = WW'($urandom_range(0, 131072) - 65536);
                bus.w_q = WW'($urandom_range(0, 131072) - 65536);
            end
            bus.w_commit  = ($urandom_range(0, 29) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.w_wr      = 1'b0;
        bus.w_commit  = 1'b0;
        bus.out_ready = 1'b1;
        idle(8);
        chk("random_drained", expq.size(), 0);
        chk("random_idle_valid", longint'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
